// File: rtl/fixed_point_pkg.sv
// Shared fixed-point defaults and saturation helpers.
// Used by the pipelined multiplier and its rounding/saturation stage.
`ifndef FIXED_W
`define FIXED_W 16
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 8
`endif

package fixed_point_pkg;

    localparam int FIXED_W_DEF      = `FIXED_W;
    localparam int FIXED_FRAC_W_DEF = `FIXED_FRACTION_W;

    // Low w bits hold the most positive / most negative w-bit value.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/fixed_point_round_sat.sv
// Rounds, rescales and range-checks a full-width signed product.
// Purely combinational; sits between the product and result stages.
module fixed_point_round_sat
    import fixed_point_pkg::*;
#(
    parameter int W      = `FIXED_W,
    parameter int FRAC_W = `FIXED_FRACTION_W
) (
    input  logic signed [2*W-1:0] prod,
    input  logic                  round_en,
    input  logic                  sat_en,
    output logic        [W-1:0]   result,
    output logic                  overflow
);

    localparam logic [W-1:0] MAX_V = W'(sat_max(W));
    localparam logic [W-1:0] MIN_V = W'(sat_min(W));

    logic signed [2*W:0] ext;
    logic signed [2*W:0] rc;
    logic signed [2*W:0] r;
    logic signed [2*W:0] q;
    logic        [W+1:0] hi;

    // One guard bit so the half-LSB addition never wraps.
    always_comb begin
        ext            = {prod[2*W-1], prod};
        rc             = '0;
        rc[FRAC_W-1]   = round_en;
        r              = ext + rc;
        q              = r >>> FRAC_W;
        hi             = q[2*W:W-1];
        overflow       = !((&hi) || !(|hi));
        result         = q[W-1:0];
        if (overflow && sat_en) begin
            result = r[2*W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/fixed_point_mul_pipe.sv
// Three-stage signed fixed-point multiplier with valid/ready flow control
// and a saturating overflow event counter.
module fixed_point_mul_pipe
    import fixed_point_pkg::*;
#(
    parameter int W      = `FIXED_W,
    parameter int FRAC_W = `FIXED_FRACTION_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     op1,
    input  logic [W-1:0]     op2,
    input  logic             round_en,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic             overflow,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clear
);

    localparam int PW = 2 * W;

    typedef struct packed {
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic                rnd;
        logic                sat;
    } s1_t;

    typedef struct packed {
        logic signed [PW-1:0] p;
        logic                 rnd;
        logic                 sat;
    } s2_t;

    logic         adv;
    logic         v1, v2, v3;
    s1_t          s1;
    s2_t          s2;
    logic [W-1:0] rs_res;
    logic         rs_ovf;
    logic         ovf_hs;

    // Whole pipe moves in lockstep; bubbles are held, not squeezed out.
    assign adv       = out_ready || !v3;
    assign in_ready  = adv;
    assign out_valid = v3;
    assign ovf_hs    = v3 && out_ready && overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            s1       <= '0;
            s2       <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (adv) begin
            v1       <= in_valid;
            v2       <= v1;
            v3       <= v2;
            s1       <= '{a: op1, b: op2, rnd: round_en, sat: sat_en};
            s2.p     <= PW'(s1.a) * PW'(s1.b);
            s2.rnd   <= s1.rnd;
            s2.sat   <= s1.sat;
            result   <= rs_res;
            overflow <= rs_ovf;
        end
    end

    fixed_point_round_sat #(
        .W      (W),
        .FRAC_W (FRAC_W)
    ) u_round_sat (
        .prod     (s2.p),
        .round_en (s2.rnd),
        .sat_en   (s2.sat),
        .result   (rs_res),
        .overflow (rs_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (ovf_clear) begin
            ovf_count <= '0;
        end else if (ovf_hs && !(&ovf_count)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: doc/fixed_point_mul_pipe.md
# fixed_point_mul_pipe

Pipelined, parametrised signed fixed-point multiplier with valid/ready handshake. Each transaction selects rounding (truncate or round-half-up) and overflow handling (saturate or wrap). A saturating overflow event counter is kept. It is the clocked successor to the combinational fixed-point multiplier and sits in the shader/transform datapath, where operands arrive as streams and back-pressure is required.

## Interface
Parameters:
- W, default `FIXED_W: total operand/result width, signed two's complement; legal range ≥ 4.
- FRAC_W, default `FIXED_FRACTION_W: fraction bits; 1 ≤ FRAC_W < W.
- CNT_W, default 16: width of the overflow event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- op1, op2  in  W each  signed Q(W-FRAC_W).FRAC_W operands.
- round_en  in  1  1 = round half up (toward +inf at .5); 0 = truncate (floor).
- sat_en  in  1  1 = clamp on overflow; 0 = wrap (keep low W bits).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- result  out  W  signed product.
- overflow  out  1  true result was not representable in W bits; qualified by out_valid.
- ovf_count  out  CNT_W  number of delivered beats with overflow=1; saturates at all-ones.
- ovf_clear  in  1  synchronous clear of ovf_count.

## Operation
- Three register stages, S1 → S2 → S3:
  - S1 captures op1, op2, round_en and sat_en.
  - S2 holds the full signed 2W-bit product.
  - S3 holds result and overflow.
- Each stage carries a valid bit.
- Arithmetic:
  - P = op1 × op2, signed, 2W bits. Computed as 2W+1 bits internally, so that adding the rounding constant can never wrap.
  - Rounding: R = P + 2^(FRAC_W-1) if round_en, else R = P.
  - Shift: Q = R >>> FRAC_W, arithmetic.
  - Overflow: overflow = 1 unless every bit of Q from bit W-1 up to the MSB equals Q[W-1].
- Result selection:
  - No overflow: result = Q[W-1:0].
  - Overflow with sat_en = 1: result = 2^(W-1)-1 if R ≥ 0, else -2^(W-1).
  - Overflow with sat_en = 0: result = Q[W-1:0] (wrap).
- Overflow is reported identically in both sat_en modes.
- Mode bits travel with their operands. Changing round_en or sat_en between beats affects only the beats that carry the new values.
- Counter:
  - ovf_count increments on each output handshake (out_valid && out_ready) with overflow = 1.
  - It holds at 2^CNT_W-1 once it reaches that value.
  - If ovf_clear and an incrementing handshake occur in the same cycle, clear wins and the count becomes 0.

## Timing
- Global advance condition: adv = out_ready || !out_valid. All stages shift together when adv = 1.
- in_ready = adv, purely combinational from out_ready and S3 valid.
- A beat is accepted on a rising edge with in_valid && in_ready. A beat accepted in cycle N appears at result in cycle N+3 if no stall occurs.
- Stall behaviour:
  - When adv = 0, every stage register holds, including bubbles. Bubbles are not collapsed.
  - result and overflow are stable while out_valid && !out_ready.
- Sustained throughput is one beat per cycle when out_ready is held at 1.
- Reset, asynchronous on rst_n low:
  - All valid bits clear, so out_valid = 0.
  - result = 0, overflow = 0, ovf_count = 0.
  - in_ready = 1 once rst_n is high. Beats in flight are discarded.
- Data registers need not reset; only the valid bits and the outputs listed above are required to.

## Structure
- The fixed_point package gains:
  - the `FIXED_W and `FIXED_FRACTION_W defaults;
  - a helper constant function for the max/min saturation values of width W.
- One combinational sub-module, fixed_point_round_sat:
  - input: 2W-bit product, round_en, sat_en;
  - output: W-bit result and overflow.
  - It sits between S2 and S3, so it can be unit-tested standalone.
- Handshake and stage control live in the top module.

## Test plan
All scenarios use W=16, FRAC_W=8 (Q8.8) and out_ready=1 unless stated.
- Basic products:
  - 0x0180 × 0x0200 → 0x0300, overflow 0.
  - 0xFF00 × 0x0100 → 0xFF00, overflow 0.
  - Each result arrives 3 cycles after its accept.
- Rounding:
  - 0x0001 × 0x0080: truncate → 0x0000; round → 0x0001.
  - 0xFFFF × 0x0080: truncate → 0xFFFF; round → 0x0000.
- Overflow:
  - 0x7FFF × 0x7FFF: sat → 0x7FFF, overflow 1; wrap → 0xFF00, overflow 1.
  - 0x8000 × 0x8000 with sat → 0x7FFF, overflow 1.
  - 0x8000 × 0x7FFF with sat → 0x8000, overflow 1.
- Back-pressure:
  - Stream 10 beats and toggle out_ready in the pattern 1,0,0,1.
  - Required: every result matches its operands in order, nothing is dropped or duplicated, and result is stable during stalls.
  - in_ready must equal adv in every cycle.
- Counter:
  - Deliver 3 overflow beats → ovf_count = 3.
  - Assert ovf_clear in the same cycle as a 4th overflow handshake → 0.
  - Run CNT_W=2 with 5 overflow beats → holds at 3.
- Reset mid-stream:
  - Drop rst_n while S1–S3 are full → out_valid = 0 and ovf_count = 0 immediately.
  - After release, the first new beat is the first output seen.
